// File: rtl/model_pingpong_buffer.sv
// Double-banked writable model buffer: the shadow bank is streamed in while the active bank serves reads.
// Optional build macro MODEL_BUF_PARITY_EN adds per-word even parity, checked on every read.
module model_pingpong_buffer #(
  parameter int unsigned addrLen = 10,
  parameter int unsigned dataLen = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic [addrLen-1:0] load_base,
  input  logic [addrLen:0]   load_len,
  input  logic               ld_valid,
  input  logic [dataLen-1:0] ld_data,
  output logic               ld_ready,
  output logic               load_busy,
  output logic               load_done,
  input  logic               swap_req,
  output logic               active_bank,
  input  logic               rd_en,
  input  logic [addrLen-1:0] rd_addr,
  output logic [dataLen-1:0] data_out,
  output logic               rd_valid,
  output logic               parity_err
);
  localparam int unsigned DEPTH = 2**addrLen;
  localparam int unsigned LEN_W = addrLen + 1;
`ifdef MODEL_BUF_PARITY_EN
  localparam int unsigned WORD_W = dataLen + 1;
`else
  localparam int unsigned WORD_W = dataLen;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [addrLen-1:0] wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               tgt_q, tgt_d;
  logic               active_bank_q, active_bank_d;
  logic               swap_pending_q, swap_pending_d;
  logic               ld_ready_q, ld_ready_d;
  logic               load_busy_q, load_busy_d;
  logic               load_done_q, load_done_d;
  logic [dataLen-1:0] data_out_q, data_out_d;
  logic               rd_valid_q, rd_valid_d;
  logic               swap_fire_c;
  logic               wr_en_c;
  logic [WORD_W-1:0]  wr_word_c;
  logic [WORD_W-1:0]  rd_word_c;

  // Both banks live in one array; the bank select is the top index bit.
  logic [WORD_W-1:0]  mem [2*DEPTH];

  // Load FSM, swap scheduling and read path.
  always_comb begin
    state_d        = state_q;
    wr_addr_d      = wr_addr_q;
    remaining_d    = remaining_q;
    tgt_d          = tgt_q;
    active_bank_d  = active_bank_q;
    swap_pending_d = swap_pending_q;
    wr_en_c        = 1'b0;
    swap_fire_c    = (state_q == S_IDLE) && (swap_req || swap_pending_q);

    if (swap_fire_c) begin
      active_bank_d  = ~active_bank_q;
      swap_pending_d = 1'b0;
    end else if (swap_req) begin
      swap_pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          wr_addr_d   = load_base;
          remaining_d = (load_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : load_len;
          // A swap firing this cycle turns the current active bank into the shadow.
          tgt_d       = swap_fire_c ? active_bank_q : ~active_bank_q;
          state_d     = (load_len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          wr_en_c     = 1'b1;
          wr_addr_d   = wr_addr_q + addrLen'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ld_ready_d  = (state_d == S_LOAD);
    load_busy_d = (state_d != S_IDLE);
    load_done_d = (state_d == S_DONE);

    rd_word_c  = mem[{active_bank_q, rd_addr}];
    rd_valid_d = rd_en;
    data_out_d = rd_en ? rd_word_c[dataLen-1:0] : data_out_q;
  end

`ifdef MODEL_BUF_PARITY_EN
  logic parity_err_q, parity_err_d;

  always_comb begin
    wr_word_c    = {^ld_data, ld_data};
    parity_err_d = rd_en && (^rd_word_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_err_q <= 1'b0;
    else       parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  always_comb wr_word_c = ld_data;

  assign parity_err = 1'b0;
`endif

  // Bank storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[{tgt_q, wr_addr_q}] <= wr_word_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wr_addr_q      <= '0;
      remaining_q    <= '0;
      tgt_q          <= 1'b0;
      active_bank_q  <= 1'b0;
      swap_pending_q <= 1'b0;
      ld_ready_q     <= 1'b0;
      load_busy_q    <= 1'b0;
      load_done_q    <= 1'b0;
      data_out_q     <= '0;
      rd_valid_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_addr_q      <= wr_addr_d;
      remaining_q    <= remaining_d;
      tgt_q          <= tgt_d;
      active_bank_q  <= active_bank_d;
      swap_pending_q <= swap_pending_d;
      ld_ready_q     <= ld_ready_d;
      load_busy_q    <= load_busy_d;
      load_done_q    <= load_done_d;
      data_out_q     <= data_out_d;
      rd_valid_q     <= rd_valid_d;
    end
  end

  assign ld_ready    = ld_ready_q;
  assign load_busy   = load_busy_q;
  assign load_done   = load_done_q;
  assign active_bank = active_bank_q;
  assign data_out    = data_out_q;
  assign rd_valid    = rd_valid_q;
endmodule

// File: tb/tb_model_pingpong_buffer.sv
// Randomized scoreboard bench for model_pingpong_buffer; reference keeps both banks as plain arrays.
// Build with MODEL_BUF_PARITY_EN defined to also exercise the parity-corruption read.
module tb_model_pingpong_buffer;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 16;
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [AW:0]   load_len;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          load_busy;
  logic          load_done;
  logic          swap_req;
  logic          active_bank;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          parity_err;

  always #5 clk = ~clk;

  model_pingpong_buffer #(.addrLen(AW), .dataLen(DW)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_base(load_base),
    .load_len(load_len), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .load_busy(load_busy), .load_done(load_done), .swap_req(swap_req),
    .active_bank(active_bank), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(data_out),
    .rd_valid(rd_valid), .parity_err(parity_err)
  );

  typedef struct {
    bit            chk;
    logic [DW-1:0] d;
    bit            perr;
    int            due;
  } rd_exp_t;

  rd_exp_t       rdq[$];
  rd_exp_t       mon_e;
  logic [DW-1:0] mdl   [2][DEPTH];
  bit            known [2][DEPTH];
  int            wl0[$];
  int            wl1[$];
  bit            act;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  bit            hold_known;
  logic [DW-1:0] hold_val;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Read monitor: pops expectations exactly one cycle after issue, otherwise expects silence.
  always @(negedge clk) begin
    if (!reset) begin
      if (rdq.size() != 0 && rdq[0].due == cyc) begin
        mon_e = rdq.pop_front();
        check("rd_valid", 32'(rd_valid), 32'd1);
        check("parity_err", 32'(parity_err), 32'(mon_e.perr));
        if (mon_e.chk) check("rd_data", 32'(data_out), 32'(mon_e.d));
        hold_known = mon_e.chk;
        hold_val   = mon_e.d;
      end else begin
        check("rd_valid_idle", 32'(rd_valid), 32'd0);
        if (hold_known) check("data_hold", 32'(data_out), 32'(hold_val));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    load_start = 1'b0;
    swap_req   = 1'b0;
    ld_valid   = 1'b0;
    rd_en      = 1'b0;
  endtask

  function automatic void model_write(input bit b, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mdl[b][a] = d;
    if (!known[b][a]) begin
      if (b) wl1.push_back(int'(a));
      else   wl0.push_back(int'(a));
    end
    known[b][a] = 1'b1;
  endfunction

  function automatic logic [AW-1:0] pick_addr(input bit b);
    int n;
    n = b ? wl1.size() : wl0.size();
    if (n == 0 || $urandom_range(0, 3) == 0) return AW'($urandom);
    return b ? AW'(wl1[$urandom_range(0, n - 1)]) : AW'(wl0[$urandom_range(0, n - 1)]);
  endfunction

  task automatic issue_read_exp(input logic [AW-1:0] a, input bit chk, input logic [DW-1:0] d,
                                input bit perr);
    rd_exp_t e;
    rd_en   = 1'b1;
    rd_addr = a;
    e.chk   = chk;
    e.d     = d;
    e.perr  = perr;
    e.due   = cyc + 1;
    rdq.push_back(e);
  endtask

  task automatic issue_read(input logic [AW-1:0] a);
    issue_read_exp(a, known[act][a], mdl[act][a], 1'b0);
  endtask

  task automatic read_burst(input int k);
    for (int i = 0; i < k; i++) begin
      tick();
      if ($urandom_range(0, 3) != 0) issue_read(pick_addr(act));
    end
  endtask

  // Swap while idle, optionally reading in the same cycle (read must use the old bank).
  task automatic swap_idle(input bit with_read);
    tick();
    swap_req = 1'b1;
    if (with_read) issue_read(pick_addr(act));
    act = ~act;
    tick();
    check("active_bank_swap", 32'(active_bank), 32'(act));
  endtask

  task automatic do_load(input logic [AW-1:0] base, input int len, input bit dense,
                         input bit mid_swap, input bit same_swap, input bit rd_during);
    int n, beats, cycles, budget;
    bit tgt, pend, done_seen;
    n = (len > int'(DEPTH)) ? int'(DEPTH) : len;
    beats = 0; cycles = 0; pend = 1'b0; done_seen = 1'b0;
    budget = n * 8 + 20;
    tick();
    load_start = 1'b1;
    load_base  = base;
    load_len   = LW'(len);
    if (same_swap) begin
      swap_req = 1'b1;
      act = ~act;
    end
    tgt = ~act;
    while (!done_seen && cycles < budget) begin
      tick();
      cycles++;
      if (same_swap && cycles == 1) check("swap_with_load", 32'(active_bank), 32'(act));
      if (load_done) begin
        done_seen = 1'b1;
      end else begin
        if (ld_ready) begin
          check("busy_in_load", 32'(load_busy), 32'd1);
          if (dense || $urandom_range(0, 3) != 0) begin
            ld_valid = 1'b1;
            ld_data  = dense ? DW'(17 * (beats + 1)) : DW'($urandom);
            if (beats < n) model_write(tgt, AW'(int'(base) + beats), ld_data);
            beats++;
          end
          if (!dense && $urandom_range(0, 7) == 0) begin
            load_start = 1'b1;
            load_base  = AW'($urandom);
            load_len   = LW'($urandom_range(1, 50));
          end
          if (mid_swap && !pend && beats >= 1) begin
            swap_req = 1'b1;
            pend = 1'b1;
          end
        end
        if (rd_during && $urandom_range(0, 1) == 1) issue_read(pick_addr(act));
        if (pend) check("active_hold_in_load", 32'(active_bank), 32'(act));
      end
    end
    check("load_done_seen", 32'(load_done), 32'd1);
    check("load_beats", 32'(beats), 32'(n));
    if (dense) check("done_latency", 32'(cycles), 32'(n + 1));
    check("ready_off_in_done", 32'(ld_ready), 32'd0);
    check("busy_in_done", 32'(load_busy), 32'd1);
    if (pend) check("active_hold_done", 32'(active_bank), 32'(act));
    tick();
    check("done_pulse_1cyc", 32'(load_done), 32'd0);
    check("busy_clear", 32'(load_busy), 32'd0);
    if (pend) begin
      check("active_hold_idle", 32'(active_bank), 32'(act));
      tick();
      act = ~act;
      check("swap_after_load", 32'(active_bank), 32'(act));
    end
  endtask

  task automatic reset_mid_load();
    logic [AW-1:0] base;
    int beats;
    bit tgt;
    base = AW'($urandom);
    tick();
    load_start = 1'b1;
    load_base  = base;
    load_len   = LW'(20);
    tgt = ~act;
    beats = 0;
    for (int i = 0; i < 10 && beats < 3; i++) begin
      tick();
      if (ld_ready) begin
        ld_valid = 1'b1;
        ld_data  = DW'($urandom);
        model_write(tgt, AW'(int'(base) + beats), ld_data);
        if (beats == 0) swap_req = 1'b1;
        beats++;
      end
    end
    tick();
    reset = 1'b1;
    #1;
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_load_busy", 32'(load_busy), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_active_bank", 32'(active_bank), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    act = 1'b0;
    hold_known = 1'b1;
    hold_val = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_done_after_reset", 32'(load_done), 32'd0);
      check("no_ready_after_reset", 32'(ld_ready), 32'd0);
      check("pending_swap_cleared", 32'(active_bank), 32'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; load_start = 1'b0; load_base = '0; load_len = '0; ld_valid = 1'b0;
    ld_data = '0; swap_req = 1'b0; rd_en = 1'b0; rd_addr = '0;
    act = 1'b0; hold_known = 1'b1; hold_val = '0;
    repeat (2) @(negedge clk);
    check("reset_ld_ready", 32'(ld_ready), 32'd0);
    check("reset_load_busy", 32'(load_busy), 32'd0);
    check("reset_load_done", 32'(load_done), 32'd0);
    check("reset_active_bank", 32'(active_bank), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_parity_err", 32'(parity_err), 32'd0);
    reset = 1'b0;

    do_load(AW'(0), 4, 1'b1, 1'b0, 1'b0, 1'b1);
    swap_idle(1'b0);
    check("active_is_bank1", 32'(active_bank), 32'd1);
    tick();
    issue_read(AW'(2));
    read_burst(2);

    do_load(AW'(DEPTH - 2), 3, 1'b0, 1'b0, 1'b0, 1'b1);
    swap_idle(1'b1);
    tick(); issue_read(AW'(DEPTH - 2));
    tick(); issue_read(AW'(DEPTH - 1));
    tick(); issue_read(AW'(0));
    read_burst(2);

    do_load(AW'($urandom), 8, 1'b0, 1'b1, 1'b0, 1'b1);
    do_load(AW'($urandom), 0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_load(AW'($urandom), 6, 1'b0, 1'b0, 1'b1, 1'b1);
    read_burst(6);
    do_load(AW'($urandom), int'(DEPTH) + 1, 1'b0, 1'b0, 1'b0, 1'b1);
    swap_idle(1'b1);
    read_burst(10);

    for (int it = 0; it < 25; it++) begin
      int len;
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
      do_load(AW'($urandom), len, 1'b0, (len > 0) && ($urandom_range(0, 3) == 0),
              $urandom_range(0, 4) == 0, 1'b1);
      read_burst(int'($urandom_range(3, 10)));
      if ($urandom_range(0, 1) == 1) swap_idle(1'b1);
      read_burst(int'($urandom_range(3, 10)));
    end

    read_burst(2);
    reset_mid_load();
    swap_idle(1'b0);
    read_burst(12);

`ifdef MODEL_BUF_PARITY_EN
    begin
      logic [DW:0] w;
      do_load(AW'(100), 2, 1'b1, 1'b0, 1'b0, 1'b0);
      swap_idle(1'b0);
      tick();
      w = dut.mem[{act, AW'(100)}];
      w[0] = ~w[0];
      dut.mem[{act, AW'(100)}] <= w;
      tick();
      issue_read_exp(AW'(100), 1'b1, mdl[act][AW'(100)] ^ DW'(1), 1'b1);
      tick();
      tick();
      issue_read(AW'(101));
      read_burst(2);
    end
`endif

    repeat (3) tick();
    check("rdq_drained", 32'(rdq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
